// File: rtl/seq_detect_param.sv
// seq_detect_param: serial sequence detector with a pattern that can be
// reloaded at run time. Bits arrive MSB first, qualified by din_valid.
// Overlapping or non-overlapping detection is selected per match, and
// matches are counted in a saturating counter.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   din_valid   qualifies din
//   din         serial data bit
//   pat_load    load pat_in as the active pattern; a simultaneous din is dropped
//   pat_in      new pattern; bit PAT_W-1 is compared against the oldest bit
//   overlap_en  1: overlapping detection, 0: non-overlapping
//   cnt_clr     synchronous clear of match_cnt
//   z           registered one-cycle match pulse
//   match_cnt   saturating match count
//   pat         active pattern
module seq_detect_param #(
  parameter int unsigned       PAT_W     = 5,
  parameter logic [PAT_W-1:0]  RESET_PAT = PAT_W'(5'b11011),
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pat
);

  localparam int unsigned FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-2:0] hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-2:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [PAT_W-1:0]  pat_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              z_nxt;

  logic              accept;
  logic [PAT_W-1:0]  cand;
  logic              match;

  // Match decode: the history is only trusted once fill is saturated.
  always_comb begin
    accept = din_valid & ~pat_load;
    cand   = {hist, din};
    match  = accept && (fill == FILL_FULL) && (cand == pat);
  end

  // Next-state for history, fill, pattern, pulse and counter.
  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    pat_nxt  = pat;
    cnt_nxt  = match_cnt;
    z_nxt    = match;

    if (pat_load) begin
      pat_nxt  = pat_in;
      fill_nxt = '0;
    end else if (accept) begin
      hist_nxt = cand[PAT_W-2:0];
      if (match && !overlap_en) begin
        // Non-overlapping: demand PAT_W fresh bits before the next match.
        fill_nxt = '0;
      end else if (fill != FILL_FULL) begin
        fill_nxt = fill + FILL_W'(1);
      end
    end

    // Clear wins over the old count, but a coincident match still counts.
    if (cnt_clr) begin
      cnt_nxt = match ? CNT_W'(1) : '0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      cnt_nxt = match_cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= RESET_PAT;
      z         <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      pat       <= pat_nxt;
      z         <= z_nxt;
      match_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios followed by random traffic,
// all checked against a queue-based reference of the detection rules.
// A second instance with a 2-bit counter shares the inputs to exercise
// saturation.
module tb_seq_detect_param;

  localparam int unsigned PW = 5;

  logic          clk;
  logic          reset;
  logic          din_valid;
  logic          din;
  logic          pat_load;
  logic [PW-1:0] pat_in;
  logic          overlap_en;
  logic          cnt_clr;
  logic          z;
  logic [7:0]    match_cnt;
  logic [PW-1:0] pat;
  logic          z2;
  logic [1:0]    match_cnt2;
  logic [PW-1:0] pat2;

  int nvec  = 0;
  int nfail = 0;

  // Reference state: accepted bits since the last restart, newest at back.
  bit            mq[$];
  logic [PW-1:0] mpat;
  logic          mz;
  int            mcnt;
  int            mcnt2;

  seq_detect_param u_dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt), .pat(pat)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(match_cnt2), .pat(pat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpat  = 5'b11011;
    mz    = 1'b0;
    mcnt  = 0;
    mcnt2 = 0;
  endtask

  // One clock edge of the reference, using the inputs currently applied.
  task automatic model_edge();
    logic          hit;
    logic [PW-1:0] w;
    hit = 1'b0;
    if (pat_load) begin
      mpat = pat_in;
      mq.delete();
    end else if (din_valid) begin
      mq.push_back(din);
      if (mq.size() > PW) void'(mq.pop_front());
      if (mq.size() == PW) begin
        w = '0;
        foreach (mq[i]) w = {w[PW-2:0], mq[i]};
        hit = (w == mpat);
      end
      if (hit && !overlap_en) mq.delete();
    end
    mz = hit;
    if (cnt_clr) begin
      mcnt  = int'(hit);
      mcnt2 = int'(hit);
    end else if (hit) begin
      if (mcnt < 255) mcnt++;
      if (mcnt2 < 3) mcnt2++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".z"},    32'(z),          32'(mz));
    check({tag, ".cnt"},  32'(match_cnt),  32'(mcnt));
    check({tag, ".cnt2"}, 32'(match_cnt2), 32'(mcnt2));
    check({tag, ".pat"},  32'(pat),        32'(mpat));
  endtask

  task automatic step(input string tag, input logic v, input logic d,
                      input logic ld = 1'b0, input logic [PW-1:0] pi = '0,
                      input logic clr = 1'b0);
    din_valid = v;
    din       = d;
    pat_load  = ld;
    pat_in    = pi;
    cnt_clr   = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Pulse reset mid-cycle; we are at posedge+1 on entry.
  task automatic do_reset();
    din_valid = 1'b0; din = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset_pulse");
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] zs;
    logic [PW-1:0] rp;
    int sel;

    reset = 1'b0; din_valid = 1'b0; din = 1'b0; pat_load = 1'b0;
    pat_in = '0; overlap_en = 1'b1; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.pat_const", 32'(pat), 32'h1b);
    #2;
    reset = 1'b1;

    // Default pattern, overlapping.
    overlap_en = 1'b1;
    zs = '0;
    begin
      logic [7:0] s;
      s = 8'b11011011;
      for (int i = 0; i < 8; i++) begin
        step("ovl", 1'b1, s[7-i]);
        zs[7-i] = z;
      end
    end
    check("ovl.pulses", 32'(zs), 32'b00001001);
    check("ovl.count", 32'(match_cnt), 32'd2);

    // Same stream, non-overlapping.
    do_reset();
    overlap_en = 1'b0;
    zs = '0;
    begin
      logic [7:0] s;
      s = 8'b11011011;
      for (int i = 0; i < 8; i++) begin
        step("novl", 1'b1, s[7-i]);
        zs[7-i] = z;
      end
    end
    check("novl.pulses", 32'(zs), 32'b00001000);
    check("novl.count", 32'(match_cnt), 32'd1);

    // Valid gaps between bits.
    do_reset();
    overlap_en = 1'b1;
    zs = '0;
    begin
      logic [4:0] s;
      s = 5'b11011;
      for (int i = 0; i < 5; i++) begin
        step("gap.bit", 1'b1, s[4-i]);
        zs[4-i] = z;
        if (i < 4) for (int k = 0; k < 3; k++) step("gap.idle", 1'b0, 1'b1);
      end
    end
    check("gap.pulses", 32'(zs), 32'b00001);

    // Pattern reload with a partial sequence pending; load-cycle bit dropped.
    do_reset();
    step("rl.pre", 1'b1, 1'b1);
    step("rl.pre", 1'b1, 1'b1);
    step("rl.pre", 1'b1, 1'b0);
    step("rl.load", 1'b1, 1'b1, 1'b1, 5'b10101);
    check("rl.pat", 32'(pat), 32'b10101);
    zs = '0;
    begin
      logic [4:0] s;
      s = 5'b10101;
      for (int i = 0; i < 5; i++) begin
        step("rl.bit", 1'b1, s[4-i]);
        zs[4-i] = z;
      end
    end
    check("rl.pulses", 32'(zs), 32'b00001);

    // Stale history must not complete a match after a load.
    step("stale.load", 1'b0, 1'b0, 1'b1, 5'b10101);
    step("stale.b0", 1'b1, 1'b0);
    check("stale.z0", 32'(z), 32'd0);
    step("stale.b1", 1'b1, 1'b1);
    check("stale.z1", 32'(z), 32'd0);

    // Counter saturation on the 2-bit instance, then clear on a match edge.
    do_reset();
    overlap_en = 1'b1;
    step("sat.load", 1'b0, 1'b0, 1'b1, 5'b11111);
    for (int i = 0; i < 10; i++) step("sat.bit", 1'b1, 1'b1);
    check("sat.z", 32'(z), 32'd1);
    check("sat.cnt2", 32'(match_cnt2), 32'd3);
    step("sat.clr", 1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("clr.cnt", 32'(match_cnt), 32'd1);
    check("clr.cnt2", 32'(match_cnt2), 32'd1);

    // Asynchronous reset while z is high.
    step("mid.bit", 1'b1, 1'b1);
    check("mid.zhigh", 32'(z), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid.z", 32'(z), 32'd0);
    check("mid.cnt", 32'(match_cnt), 32'd0);
    check("mid.pat", 32'(pat), 32'h1b);
    model_reset();
    #2;
    reset = 1'b1;
    zs = '0;
    for (int i = 0; i < 4; i++) begin
      step("post.ones", 1'b1, 1'b1);
      zs[i] = z;
    end
    check("post.nomatch", 32'(zs), 32'd0);
    begin
      logic [4:0] s;
      s = 5'b11011;
      for (int i = 0; i < 5; i++) step("post.seq", 1'b1, s[4-i]);
    end

    // Random traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      logic v, d, ld, clr;
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: rp = 5'b11011;
        1: rp = 5'b10101;
        2: rp = 5'b11111;
        default: rp = 5'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) overlap_en = ~overlap_en;
      step("rand", v, d, ld, rp, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector, the successor to the fixed 11011 detector. It compares a qualified 1-bit input stream against a run-time programmable pattern of `PAT_W` bits, MSB received first. Overlapping and non-overlapping detection are selectable. It emits a registered one-cycle match pulse and keeps a saturating match count. It sits directly on a serial data link, beside the link's deserialiser.

## Interface
Parameters:
- `PAT_W`, default 5: pattern length in bits; legal range 2..32.
- `RESET_PAT`, default 5'b11011: pattern loaded at reset.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `din_valid`, in, 1: `din` is sampled only when this is 1.
- `din`, in, 1: serial data bit.
- `pat_load`, in, 1: load `pat_in` as the new pattern.
- `pat_in`, in, `PAT_W`: new pattern; bit `PAT_W-1` is compared against the oldest bit.
- `overlap_en`, in, 1: 1 selects overlapping detection; 0 selects non-overlapping.
- `cnt_clr`, in, 1: synchronous clear of `match_cnt`.
- `z`, out, 1: registered match pulse.
- `match_cnt`, out, `CNT_W`: saturating count of matches.
- `pat`, out, `PAT_W`: the currently active pattern.

## Operation
- **State:**
  - `hist`: `PAT_W-1` bits of history.
  - `fill`: count of valid history bits, range 0..`PAT_W-1`.
  - `pat`: active pattern.
  - `z`
  - `match_cnt`
- **Reset (`reset`=0, asynchronous):**
  - `hist`=0, `fill`=0, `pat`=`RESET_PAT`.
  - `z`=0, `match_cnt`=0.
- **Accepted bit:** `din_valid`=1 and `pat_load`=0.
  - Candidate word is {`hist`, `din`}.
  - The bit is a match iff `fill`==`PAT_W-1` and the candidate word equals `pat`.
  - `hist` shifts left with `din` entering at the LSB.
  - `fill` increments, saturating at `PAT_W-1`.
- **On a match:**
  - `z`<=1.
  - `match_cnt` increments, saturating at all-ones.
  - If `overlap_en`=0: `fill`<=0, so the next match needs `PAT_W` fresh bits.
  - If `overlap_en`=1: `fill` stays saturated.
  - `overlap_en` is sampled at the match edge only.
- **Non-matching edges:** on every edge without a match, `z`<=0.
- **Idle edges (`din_valid`=0):** `hist` and `fill` hold and `z`<=0. Gaps in valid never break a sequence.
- **Pattern load (`pat_load`=1):**
  - `pat`<=`pat_in`, `fill`<=0, `z`<=0.
  - `hist` is don't-care, since it is masked by `fill`.
  - `match_cnt` holds.
  - A simultaneous `din` is dropped, even when `din_valid`=1.
- **Counter clear (`cnt_clr`=1):**
  - `match_cnt`<=0.
  - If a match occurs on the same edge, `match_cnt`<=1.

## Timing
- **Latency:** `z` rises on the clock edge that samples the final pattern bit, is visible for exactly one cycle, then falls.
- **Back-to-back matches:**
  - Overlap mode: `z` is high on consecutive cycles when the stream allows it (e.g. all-ones pattern against all-ones input).
  - Non-overlap mode: the minimum spacing between matches is `PAT_W` accepted bits.
- **Load-to-match:** the first possible match after a `pat_load` edge is `PAT_W` accepted bits later.
- **Counter timing:** `match_cnt` updates on the same edge as `z`.
- **Mid-operation reset:** asserting `reset` clears all outputs immediately, without waiting for a clock edge. After release, the first edge starts with `fill`=0.
- **Outputs:** all outputs are registered. There is no combinational path from input to output.

## Test plan
- **Reset default, overlap:** reset with default parameters, `overlap_en`=1, feed 1,1,0,1,1,0,1,1 with `din_valid`=1 every cycle.
  - Require `z` pulses after bits 5 and 8, and `match_cnt`=2.
- **Reset default, non-overlap:** same stream as above with `overlap_en`=0.
  - Require a single `z` pulse after bit 5 and `match_cnt`=1.
- **Valid gaps:** deliver 1,1,0,1,1 with `din_valid` low for 3 cycles between each bit.
  - Require one `z` pulse on the edge that samples the 5th bit, and none during the gaps.
- **Pattern reload:**
  - Partial sequence: feed 1,1,0, then `pat_load` with `pat_in`=5'b10101 while `din_valid`=1 and `din`=1, then feed 1,0,1,0,1.
    - Require `pat`=10101, the load-cycle bit dropped, and a match exactly on the 5th post-load bit.
  - Stale history: feed 0,1 immediately after a load.
    - Require no match from stale history.
- **Counter saturation and clear:** with `CNT_W`=2, drive all-ones `din` with pattern 11111 in overlap mode.
  - Require `match_cnt` to saturate at 3 while `z` stays high.
  - Assert `cnt_clr` on a match edge: require `match_cnt`=1.
- **Mid-pulse reset:** assert `reset` asynchronously mid-cycle while `z`=1.
  - Require `z`=0 and `match_cnt`=0 immediately.
  - After release, require no match before 5 accepted bits.
